reset_sequencer: RTL and testbench

//  Controller for the MakeReset-style reset generators. Owns NDOM reset domains and drives

---
 rtl/reset_seq_pkg.sv | 33 +++
 rtl/reset_seq_rr_arb.sv | 34 +++
 rtl/reset_sequencer.sv | 178 +++++++++++++++++
 tb/tb_reset_sequencer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the reset sequencer: FSM state encoding,
// counter sizing and a lowest-set-bit finder used to order domain releases.
package reset_seq_pkg;

    typedef enum logic [2:0] {
        ST_PWRON   = 3'd0,
        ST_IDLE    = 3'd1,
        ST_ASSERT  = 3'd2,
        ST_RELEASE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Widest domain vector the lowest-set-bit helper can scan.
    localparam int MAX_VEC = 32;

    // Counter must hold the larger of the hold and stagger intervals.
    function automatic int cnt_width(input int hold, input int stagger);
        int m;
        m = (hold > stagger) ? hold : stagger;
        return $clog2(m + 1);
    endfunction

    // Index of the lowest set bit; MAX_VEC when the vector is empty.
    function automatic int lowest_set_idx(input logic [MAX_VEC-1:0] vec);
        int idx;
        idx = MAX_VEC;
        for (int i = MAX_VEC - 1; i >= 0; i--) begin
            idx = vec[i] ? i : idx;
        end
        return idx;
    endfunction

endpackage

// File: rtl/reset_seq_rr_arb.sv
// Round-robin arbiter: searches upward from the pointer (wrapping) for the
// first active request and returns a one-hot grant plus the next pointer.
module reset_seq_rr_arb #(
    parameter int NREQ = 2,
    parameter int PW   = 1
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [PW-1:0]   o_next_ptr,
    output logic            o_any
);

    // Rotating priority search; the first hit wins and later hits are ignored.
    always_comb begin
        int  idx;
        logic w_hit;
        o_gnt      = '0;
        o_next_ptr = i_ptr;
        o_any      = 1'b0;
        idx        = 0;
        w_hit      = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(i_ptr) + i) % NREQ;
            for (int j = 0; j < NREQ; j++) begin
                w_hit      = !o_any && (j == idx) && i_req[j];
                o_gnt[j]   = o_gnt[j] | w_hit;
                o_next_ptr = w_hit ? PW'((j + 1) % NREQ) : o_next_ptr;
                o_any      = o_any | w_hit;
            end
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: holds all domains at power-on and releases them in index
// order with a fixed stagger, then serves requesters (round-robin) that ask
// for a masked set of domains to be pulsed through the same hold/release
// pattern, acknowledging each completed sequence with a one-cycle ACK.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NDOM           = 4,
    parameter int NREQ           = 2,
    parameter int HOLD_CYCLES    = 8,
    parameter int STAGGER_CYCLES = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NREQ-1:0]      i_req,
    input  logic [NREQ*NDOM-1:0] i_req_mask,
    output logic [NREQ-1:0]      o_gnt,
    output logic [NREQ-1:0]      o_ack,
    output logic [NDOM-1:0]      o_out_rst,
    output logic                 o_busy
);

    localparam int CW = cnt_width(HOLD_CYCLES, STAGGER_CYCLES);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t            r_state,     w_state;
    logic [CW-1:0]     r_cnt,       w_cnt;
    logic [PW-1:0]     r_ptr,       w_ptr;
    logic [NDOM-1:0]   r_mask,      w_mask;
    logic [NDOM-1:0]   r_remaining, w_remaining;
    logic [NDOM-1:0]   r_out_rst,   w_out_rst;
    logic [NREQ-1:0]   r_gnt,       w_gnt;
    logic [NREQ-1:0]   r_ack,       w_ack;
    logic              r_busy,      w_busy;

    logic [NREQ-1:0]   w_arb_gnt;
    logic [PW-1:0]     w_arb_ptr;
    logic              w_arb_any;
    logic [NDOM-1:0]   w_sel_mask;
    logic [NDOM-1:0]   w_lsb;
    logic [MAX_VEC-1:0] w_rem_ext;
    int                w_lsb_idx;

    reset_seq_rr_arb #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .i_req      (i_req),
        .i_ptr      (r_ptr),
        .o_gnt      (w_arb_gnt),
        .o_next_ptr (w_arb_ptr),
        .o_any      (w_arb_any)
    );

    assign w_rem_ext = MAX_VEC'(r_remaining);
    assign w_lsb_idx = lowest_set_idx(w_rem_ext);

    // One-hot of the next domain to release and mask of the winning requester.
    always_comb begin
        w_lsb      = '0;
        w_sel_mask = '0;
        for (int k = 0; k < NDOM; k++) begin
            w_lsb[k] = (k == w_lsb_idx);
        end
        for (int i = 0; i < NREQ; i++) begin
            w_sel_mask = w_sel_mask | (w_arb_gnt[i] ? i_req_mask[i*NDOM +: NDOM] : '0);
        end
    end

    // Next-state and next-output logic for the sequencing FSM.
    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_ptr       = r_ptr;
        w_mask      = r_mask;
        w_remaining = r_remaining;
        w_out_rst   = r_out_rst;
        w_gnt       = r_gnt;
        w_ack       = '0;
        w_busy      = r_busy;
        case (r_state)
            // Power-on shares the hold path with a request; its mask is all ones.
            ST_PWRON, ST_ASSERT: begin
                if (r_cnt == '0) begin
                    w_out_rst   = (r_out_rst | r_mask) & ~w_lsb;
                    w_remaining = r_remaining & ~w_lsb;
                    w_cnt       = CW'(STAGGER_CYCLES - 1);
                    if (w_remaining == '0) begin
                        w_state = ST_DONE;
                    end else begin
                        w_state = ST_RELEASE;
                    end
                end else begin
                    w_out_rst = r_out_rst | r_mask;
                    w_cnt     = r_cnt - CW'(1);
                end
            end
            ST_RELEASE: begin
                if (r_cnt == '0) begin
                    w_out_rst   = r_out_rst & ~w_lsb;
                    w_remaining = r_remaining & ~w_lsb;
                    w_cnt       = CW'(STAGGER_CYCLES - 1);
                    if (w_remaining == '0) begin
                        w_state = ST_DONE;
                    end else begin
                        w_state = ST_RELEASE;
                    end
                end else begin
                    w_cnt = r_cnt - CW'(1);
                end
            end
            ST_IDLE: begin
                if (w_arb_any) begin
                    w_gnt       = w_arb_gnt;
                    w_ptr       = w_arb_ptr;
                    w_mask      = w_sel_mask;
                    w_remaining = w_sel_mask;
                    w_cnt       = CW'(HOLD_CYCLES);
                    w_busy      = 1'b1;
                    if (w_sel_mask == '0) begin
                        w_state = ST_DONE;
                    end else begin
                        w_state = ST_ASSERT;
                    end
                end else begin
                    w_state = ST_IDLE;
                end
            end
            // A granted sequence spends one cycle pulsing ACK before going idle;
            // the power-on sequence has no owner and goes idle directly.
            ST_DONE: begin
                if ((r_gnt != '0) && (r_ack == '0)) begin
                    w_ack = r_gnt;
                end else begin
                    w_gnt   = '0;
                    w_busy  = 1'b0;
                    w_state = ST_IDLE;
                end
            end
            default: begin
                w_gnt   = '0;
                w_busy  = 1'b0;
                w_state = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset holds every domain and restarts power-on.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_PWRON;
            r_cnt       <= CW'(HOLD_CYCLES);
            r_ptr       <= '0;
            r_mask      <= '1;
            r_remaining <= '1;
            r_out_rst   <= '1;
            r_gnt       <= '0;
            r_ack       <= '0;
            r_busy      <= 1'b1;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_ptr       <= w_ptr;
            r_mask      <= w_mask;
            r_remaining <= w_remaining;
            r_out_rst   <= w_out_rst;
            r_gnt       <= w_gnt;
            r_ack       <= w_ack;
            r_busy      <= w_busy;
        end
    end

    assign o_gnt     = r_gnt;
    assign o_ack     = r_ack;
    assign o_out_rst = r_out_rst;
    assign o_busy    = r_busy;

endmodule

// File: tb/tb_reset_sequencer.sv
// Randomized bench for reset_sequencer. The reference model works from event
// times: power-on release times per domain, and for each granted sequence the
// grant cycle, per-domain release cycles, ACK cycle and idle cycle.
module tb_reset_sequencer;

    localparam int ND = 4;
    localparam int NR = 2;
    localparam int H  = 8;
    localparam int S  = 2;
    localparam int PON_END = H + (ND - 1) * S + 1;

    logic               clk;
    logic               rst;
    logic [NR-1:0]      req;
    logic [NR*ND-1:0]   masks;
    logic [NR-1:0]      o_gnt;
    logic [NR-1:0]      o_ack;
    logic [ND-1:0]      o_out_rst;
    logic               o_busy;

    int n_cmp;
    int n_bad;
    int e;

    // model state
    int             ptr_m;
    bit             seq_valid;
    int             seq_st;
    int             seq_owner;
    int             ack_e;
    int             idle_e;
    int             next_grant;
    int             rel [ND];
    logic [ND-1:0]  seq_mask;
    logic [NR-1:0]  exp_gnt;
    logic [NR-1:0]  exp_ack;
    logic [ND-1:0]  exp_out;
    logic           exp_busy;
    int             rq_state [NR];

    reset_sequencer #(
        .NDOM           (ND),
        .NREQ           (NR),
        .HOLD_CYCLES    (H),
        .STAGGER_CYCLES (S)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_req      (req),
        .i_req_mask (masks),
        .o_gnt      (o_gnt),
        .o_ack      (o_ack),
        .o_out_rst  (o_out_rst),
        .o_busy     (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, expv, e);
        end
    endtask

    task automatic model_reset();
        e          = -1;
        ptr_m      = 0;
        seq_valid  = 1'b0;
        next_grant = PON_END + 1;
        exp_ack    = '0;
        for (int i = 0; i < NR; i++) rq_state[i] = 0;
    endtask

    task automatic model_step();
        int own;
        int n;
        bit active;
        if (e >= next_grant && req != '0) begin
            own = -1;
            for (int k = 0; k < NR; k++) begin
                int c;
                c = (ptr_m + k) % NR;
                if (own < 0 && req[c]) own = c;
            end
            ptr_m     = (own + 1) % NR;
            seq_valid = 1'b1;
            seq_st    = e;
            seq_owner = own;
            seq_mask  = masks[own*ND +: ND];
            n = 0;
            for (int k = 0; k < ND; k++) begin
                if (seq_mask[k]) begin
                    rel[k] = e + H + 1 + n * S;
                    n++;
                end else begin
                    rel[k] = 0;
                end
            end
            ack_e      = (n == 0) ? e + 1 : e + H + 1 + (n - 1) * S + 1;
            idle_e     = ack_e + 1;
            next_grant = idle_e + 1;
        end
        exp_out = '0;
        for (int k = 0; k < ND; k++) begin
            if (e < H + k * S) exp_out[k] = 1'b1;
            if (seq_valid && seq_mask[k] && e > seq_st && e < rel[k]) exp_out[k] = 1'b1;
        end
        active   = seq_valid && e >= seq_st && e < idle_e;
        exp_busy = (e < PON_END) || active;
        exp_gnt  = '0;
        exp_ack  = '0;
        if (active) exp_gnt[seq_owner] = 1'b1;
        if (seq_valid && e == ack_e) exp_ack[seq_owner] = 1'b1;
    endtask

    function automatic logic [ND-1:0] rand_mask();
        if ($urandom_range(0, 15) < 3) return '0;
        return ND'($urandom);
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < NR; i++) begin
            if (rq_state[i] != 0 && exp_ack[i]) begin
                rq_state[i] = 0;
                req[i] = 1'b0;
            end else if (rq_state[i] == 0) begin
                if ($urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    rq_state[i] = 1;
                end
            end else if (rq_state[i] == 1 && seq_valid && seq_owner == i &&
                         e >= seq_st && e < ack_e && $urandom_range(0, 7) == 0) begin
                req[i] = 1'b0;
                rq_state[i] = 2;
            end
            if ($urandom_range(0, 2) == 0) masks[i*ND +: ND] = rand_mask();
        end
    endtask

    task automatic check_outputs(input string pfx);
        check_value({pfx, "_out_rst"}, 32'(o_out_rst), 32'(exp_out));
        check_value({pfx, "_gnt"},     32'(o_gnt),     32'(exp_gnt));
        check_value({pfx, "_ack"},     32'(o_ack),     32'(exp_ack));
        check_value({pfx, "_busy"},    32'(o_busy),    32'(exp_busy));
    endtask

    task automatic check_reset_values(input string pfx);
        exp_out  = '1;
        exp_gnt  = '0;
        exp_ack  = '0;
        exp_busy = 1'b1;
        check_outputs(pfx);
    endtask

    initial begin
        bit did_rst;
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        req   = '0;
        masks = '0;
        e     = -1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("por");
        for (int ep = 0; ep < 4; ep++) begin
            @(negedge clk);
            if (ep > 0) begin
                rst = 1'b1;
                req = '0;
                repeat (2) @(negedge clk);
            end
            rst = 1'b0;
            model_reset();
            did_rst = 1'b0;
            for (int cyc = 0; cyc < 600; cyc++) begin
                drive_inputs();
                @(posedge clk);
                e++;
                model_step();
                #1;
                check_outputs("run");
                if ((ep == 1 || ep == 3) && !did_rst && seq_valid &&
                    e == seq_st + 5 && seq_mask != '0) begin
                    did_rst = 1'b1;
                    #2;
                    rst = 1'b1;
                    #1;
                    check_reset_values("async_rst");
                    req = '0;
                    @(negedge clk);
                    @(negedge clk);
                    rst = 1'b0;
                    model_reset();
                end else begin
                    @(negedge clk);
                end
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
